// File: rtl/ccu_nibble_cipher_pkg.sv
// Shared types, S-box tables and word-level helpers for the nibble-serial SPN cipher.
// The EXPAND state exists only when CCU_NIBBLE_CIPHER_DECRYPT_EN is defined.
package ccu_cipher_pkg;

  localparam int unsigned MAXW = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
`ifdef CCU_NIBBLE_CIPHER_DECRYPT_EN
    ST_EXPAND,
`endif
    ST_RUN,
    ST_UNLOAD
  } state_t;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // Helpers operate on a MAXW container; only the low w bits are meaningful.
  function automatic logic [MAXW-1:0] rotl_word(input logic [MAXW-1:0] x, input int unsigned w);
    logic [MAXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAXW; i++)
      if (i < w) r[6'((i + 4) % w)] = x[6'(i)];
    return r;
  endfunction

  function automatic logic [MAXW-1:0] rotr_word(input logic [MAXW-1:0] x, input int unsigned w);
    logic [MAXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAXW; i++)
      if (i < w) r[6'(i)] = x[6'((i + 4) % w)];
    return r;
  endfunction

  function automatic logic [MAXW-1:0] sbox_word(input logic [MAXW-1:0] x, input int unsigned w);
    logic [MAXW-1:0] r;
    r = '0;
    for (int unsigned n = 0; n < MAXW / 4; n++)
      if (n * 4 < w) r[6'(n * 4) +: 4] = SBOX[x[6'(n * 4) +: 4]];
    return r;
  endfunction

  function automatic logic [MAXW-1:0] inv_sbox_word(input logic [MAXW-1:0] x, input int unsigned w);
    logic [MAXW-1:0] r;
    r = '0;
    for (int unsigned n = 0; n < MAXW / 4; n++)
      if (n * 4 < w) r[6'(n * 4) +: 4] = SBOX_INV[x[6'(n * 4) +: 4]];
    return r;
  endfunction

  function automatic logic [MAXW-1:0] key_step(input logic [MAXW-1:0] k, input int unsigned w,
                                               input logic [3:0] c);
    logic [MAXW-1:0] r;
    r = rotl_word(k, w);
    r[3:0] = r[3:0] ^ c;
    return r;
  endfunction

  function automatic logic [MAXW-1:0] key_unstep(input logic [MAXW-1:0] k, input int unsigned w,
                                                 input logic [3:0] c);
    logic [MAXW-1:0] t;
    t = k;
    t[3:0] = t[3:0] ^ c;
    return rotr_word(t, w);
  endfunction

endpackage

// File: rtl/ccu_nibble_cipher_sbox4.sv
// 4-bit PRESENT S-box, forward or inverse selected by inv.
module ccu_sbox4
  import ccu_cipher_pkg::*;
(
  input  logic [3:0] x,
  input  logic       inv,
  output logic [3:0] y
);

  assign y = inv ? SBOX_INV[x] : SBOX[x];

endmodule

// File: rtl/ccu_nibble_cipher.sv
// Nibble-serial toy SPN cipher with valid/ready load/unload and a one-round-per-cycle engine.
// Decryption (mode=1, EXPAND state) is built only with CCU_NIBBLE_CIPHER_DECRYPT_EN.
module ccu_nibble_cipher
  import ccu_cipher_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned ROUNDS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] data_in,
  input  logic [3:0] key_in,
  input  logic       mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] data_out,
  output logic       busy
);

  localparam int unsigned W   = 4 * NIBBLES;
  localparam int unsigned NCW = $clog2(NIBBLES + 1);
  localparam int unsigned RCW = $clog2(ROUNDS + 1);

  state_t         state, state_next, load_done;
  logic [W-1:0]   s, k;
  logic [NCW-1:0] ncnt;
  logic [RCW-1:0] rcnt;
  logic           accept, nib_last, rnd_last, dec;
  logic [W-1:0]   sb_in, sb_out, s_round, k_fwd, k_round;

  assign accept   = in_valid && in_ready;
  assign nib_last = (ncnt == NCW'(NIBBLES - 1));
  assign rnd_last = (rcnt == RCW'(ROUNDS - 1));

`ifdef CCU_NIBBLE_CIPHER_DECRYPT_EN
  logic mode_r;
  assign dec = mode_r;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign dec = 1'b0;
`endif

  for (genvar g = 0; g < NIBBLES; g++) begin : g_sbox
    ccu_sbox4 u_sbox (
      .x   (sb_in[4*g +: 4]),
      .inv (dec),
      .y   (sb_out[4*g +: 4])
    );
  end

  // Decrypt folds the initial whitening with k_ROUNDS into the first RUN cycle.
  always_comb begin
    sb_in = s ^ k;
`ifdef CCU_NIBBLE_CIPHER_DECRYPT_EN
    if (dec) sb_in = W'(rotr_word(MAXW'((rcnt == '0) ? (s ^ k) : s), W));
`endif
  end

  always_comb begin
    k_fwd   = W'(key_step(MAXW'(k), W, 4'(rcnt) + 4'd1));
    k_round = k_fwd;
    s_round = W'(rotl_word(MAXW'(sb_out), W));
    if (rnd_last) s_round = s_round ^ k_fwd;
`ifdef CCU_NIBBLE_CIPHER_DECRYPT_EN
    if (dec) begin
      k_round = W'(key_unstep(MAXW'(k), W, 4'(ROUNDS) - 4'(rcnt)));
      s_round = sb_out ^ k_round;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
`ifdef CCU_NIBBLE_CIPHER_DECRYPT_EN
    load_done  = (((state == ST_IDLE) ? mode : mode_r) == 1'b1) ? ST_EXPAND : ST_RUN;
`else
    load_done  = ST_RUN;
`endif
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = nib_last ? load_done : ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && nib_last) state_next = load_done;
      end
`ifdef CCU_NIBBLE_CIPHER_DECRYPT_EN
      ST_EXPAND: if (rnd_last) state_next = ST_RUN;
`endif
      ST_RUN:    if (rnd_last) state_next = ST_UNLOAD;
      ST_UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready && nib_last) state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  assign data_out = out_valid ? s[W-1 -: 4] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      s    <= '0;
      k    <= '0;
      ncnt <= '0;
      rcnt <= '0;
`ifdef CCU_NIBBLE_CIPHER_DECRYPT_EN
      mode_r <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            s    <= W'({s, data_in});
            k    <= W'({k, key_in});
            ncnt <= nib_last ? '0 : ncnt + NCW'(1);
            rcnt <= '0;
`ifdef CCU_NIBBLE_CIPHER_DECRYPT_EN
            if (state == ST_IDLE) mode_r <= mode;
`endif
          end
        end
`ifdef CCU_NIBBLE_CIPHER_DECRYPT_EN
        ST_EXPAND: begin
          k    <= k_fwd;
          rcnt <= rnd_last ? '0 : rcnt + RCW'(1);
        end
`endif
        ST_RUN: begin
          s    <= s_round;
          k    <= k_round;
          rcnt <= rnd_last ? '0 : rcnt + RCW'(1);
        end
        ST_UNLOAD: begin
          k <= '0;
          if (out_ready) begin
            s    <= W'({s, 4'h0});
            ncnt <= nib_last ? '0 : ncnt + NCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
